tt_um_seven_segment_mux_counter: RTL

//  Multi-digit BCD seconds counter with multiplexed seven-segment drive; successor to single-digit seconds block.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_decoder.sv | 27 ++
 rtl/tt_um_seven_segment_mux_counter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment constants and digit width for the seven-segment counter
package seg7_pkg;

  localparam int BCD_W = 4;

  // Segment patterns {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational BCD digit to seven-segment pattern
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [6:0]       seg
);

  // Non-BCD codes cannot occur in the counter; they show as dark.
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/tt_um_seven_segment_mux_counter.sv
// rtl/tt_um_seven_segment_mux_counter.sv - multi-digit BCD seconds counter with multiplexed seven-segment drive
module tt_um_seven_segment_mux_counter
  import seg7_pkg::*;
#(
  parameter int MAX_COUNT   = 10_000_000,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int PW = $clog2(MAX_COUNT);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int CW = DIGITS * BCD_W;

  localparam logic [PW-1:0] PRESC_LAST = PW'(MAX_COUNT - 1);
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
  localparam logic [1:0]    SEL_LAST   = 2'(DIGITS - 1);

  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ind_q, ind_d;
  logic [RW-1:0]    ref_q, ref_d;
  logic [1:0]       sel_q, sel_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       en_q, en_d;

  logic             pause, down, clr, blank_en;
  logic             tick;
  logic             carry;
  logic [BCD_W-1:0] cur_digit;
  logic [6:0]       dec_seg;
  logic             lead_zero;
  logic             unused_ok;

  assign unused_ok = ^{uio_in, ui_in[7:4]};

  assign pause    = sync2_q[0];
  assign down     = sync2_q[1];
  assign clr      = sync2_q[2];
  assign blank_en = sync2_q[3];

  // Two-stage synchroniser for the control pins.
  always_comb begin
    sync1_d = ui_in[3:0];
    sync2_d = sync1_q;
  end

  // Prescaler: counts enabled clocks, pulses tick on wrap; clear wins.
  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (clr) begin
      presc_d = '0;
    end else if (ena && !pause) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // BCD chain: ripple increment/decrement with decimal carry/borrow, plus tick indicator.
  always_comb begin
    count_d = count_q;
    ind_d   = ind_q;
    carry   = 1'b0;
    if (clr) begin
      count_d = '0;
      ind_d   = 1'b0;
    end else if (tick) begin
      ind_d = ~ind_q;
      carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        if (carry) begin
          if (down) begin
            if (count_q[i*BCD_W +: BCD_W] == 4'd0) begin
              count_d[i*BCD_W +: BCD_W] = 4'd9;
            end else begin
              count_d[i*BCD_W +: BCD_W] = count_q[i*BCD_W +: BCD_W] - 4'd1;
              carry = 1'b0;
            end
          end else begin
            if (count_q[i*BCD_W +: BCD_W] == 4'd9) begin
              count_d[i*BCD_W +: BCD_W] = 4'd0;
            end else begin
              count_d[i*BCD_W +: BCD_W] = count_q[i*BCD_W +: BCD_W] + 4'd1;
              carry = 1'b0;
            end
          end
        end
      end
    end
  end

  // Free-running refresh timer advancing the digit select on wrap.
  always_comb begin
    ref_d = ref_q + 1'b1;
    sel_d = sel_q;
    if (ref_q == REF_LAST) begin
      ref_d = '0;
      sel_d = (sel_q == SEL_LAST) ? 2'd0 : sel_q + 2'd1;
    end
  end

  // Pick the selected digit and decide whether it is a blanked leading zero.
  always_comb begin
    cur_digit = '0;
    lead_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel_q == 2'(i)) begin
        cur_digit = count_q[i*BCD_W +: BCD_W];
      end
      if ((i >= int'(sel_q)) && (count_q[i*BCD_W +: BCD_W] != 4'd0)) begin
        lead_zero = 1'b0;
      end
    end
  end

  seg7_decoder u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  // Next pin values: one-hot enable and segments for the current select.
  always_comb begin
    en_d  = 4'b0001 << sel_q;
    seg_d = dec_seg;
    if (blank_en && (sel_q != 2'd0) && lead_zero) begin
      seg_d = SEG_BLANK;
    end
  end

  // All state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      presc_q <= '0;
      count_q <= '0;
      ind_q   <= 1'b0;
      ref_q   <= '0;
      sel_q   <= 2'd0;
      seg_q   <= SEG_BLANK;
      en_q    <= 4'b0000;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      presc_q <= presc_d;
      count_q <= count_d;
      ind_q   <= ind_d;
      ref_q   <= ref_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      en_q    <= en_d;
    end
  end

  assign uo_out  = {ind_q, seg_q};
  assign uio_out = {4'b0000, en_q};
  assign uio_oe  = 8'h0F;

endmodule
